// File: rtl/alif_isi_pkg.sv
// Shared defaults, saturation constants and ISI state encoding for the ALIF ISI monitor.
package alif_isi_pkg;

  localparam int DEF_ISI_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_WIN_CYC    = 256;
  localparam int DEF_RATE_W     = 8;

  typedef logic [DEF_ISI_W-1:0] isi_t;

  localparam isi_t                  ISI_MAX  = {DEF_ISI_W{1'b1}};
  localparam logic [DEF_RATE_W-1:0] RATE_MAX = {DEF_RATE_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } isi_state_e;

endpackage

// File: rtl/alif_isi_fifo.sv
// Synchronous ISI FIFO: registered level, no write-to-read bypass, drop flag when a push hits a full FIFO.
module alif_isi_fifo
  import alif_isi_pkg::*;
#(
  parameter int W     = DEF_ISI_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_s, pop_s, wr_en_s;

  assign full_s  = (level_q == FULL_LVL);
  assign pop_s   = ready_i && (level_q != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en_s = push_i && (!full_s || pop_s);
  assign drop_o  = push_i && full_s && !pop_s;

  assign valid_o = (level_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign level_o = level_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (wr_en_s) begin
      wr_d = wr_q + AW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/alif_isi_monitor.sv
// ALIF spike statistics: inter-spike intervals into a FIFO plus windowed spike rate.
// Optional burst flag enabled by defining ALIF_ISI_BURST_EN.
module alif_isi_monitor
  import alif_isi_pkg::*;
#(
  parameter int ISI_W      = DEF_ISI_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WIN_CYC    = DEF_WIN_CYC,
  parameter int RATE_W     = DEF_RATE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        spike_in,
  input  logic [ISI_W-1:0]            burst_thr,
  output logic                        isi_valid,
  input  logic                        isi_ready,
  output logic [ISI_W-1:0]            isi_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [RATE_W-1:0]           rate_data,
  output logic                        rate_strobe,
  output logic                        burst_out
);

  localparam int WIN_W = $clog2(WIN_CYC);
  localparam logic [ISI_W-1:0]  ISI_SAT  = {ISI_W{1'b1}};
  localparam logic [RATE_W-1:0] RATE_SAT = {RATE_W{1'b1}};
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYC - 1);

  isi_state_e        state_q, state_d;
  logic [ISI_W-1:0]  gap_q, gap_d, gap_inc_s;
  logic              push_q, push_d;
  logic [ISI_W-1:0]  push_data_q, push_data_d;
  logic              overflow_q, fifo_drop_s;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [RATE_W-1:0] count_q, count_d, count_inc_s;
  logic [RATE_W-1:0] rate_data_q, rate_data_d;
  logic              rate_strobe_q, rate_strobe_d;
  logic              burst_q, burst_d;

  // gap+1 doubles as the ISI value pushed on a spike, so one saturating adder serves both.
  assign gap_inc_s   = (gap_q == ISI_SAT) ? ISI_SAT : gap_q + ISI_W'(1);
  assign count_inc_s = (spike_in && (count_q != RATE_SAT)) ? count_q + RATE_W'(1) : count_q;

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    push_d        = 1'b0;
    push_data_d   = push_data_q;
    win_d         = win_q;
    count_d       = count_q;
    rate_data_d   = rate_data_q;
    rate_strobe_d = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (spike_in) begin
            state_d = ST_ARMED;
            gap_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (spike_in) begin
            push_d      = 1'b1;
            push_data_d = gap_inc_s;
            gap_d       = '0;
          end else begin
            gap_d = gap_inc_s;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (win_q == WIN_LAST) begin
        rate_data_d   = count_inc_s;
        rate_strobe_d = 1'b1;
        count_d       = '0;
        win_d         = '0;
      end else begin
        count_d = count_inc_s;
        win_d   = win_q + WIN_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

`ifdef ALIF_ISI_BURST_EN
  assign burst_d = push_q && (push_data_q <= burst_thr);
`else
  logic unused_burst_thr;
  assign unused_burst_thr = ^burst_thr;
  assign burst_d = 1'b0;
`endif

  alif_isi_fifo #(
    .W     (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .ready_i (isi_ready),
    .valid_o (isi_valid),
    .data_o  (isi_data),
    .level_o (fifo_level),
    .drop_o  (fifo_drop_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gap_q         <= '0;
      push_q        <= 1'b0;
      push_data_q   <= '0;
      overflow_q    <= 1'b0;
      win_q         <= '0;
      count_q       <= '0;
      rate_data_q   <= '0;
      rate_strobe_q <= 1'b0;
      burst_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      push_q        <= push_d;
      push_data_q   <= push_data_d;
      overflow_q    <= overflow_q | fifo_drop_s;
      win_q         <= win_d;
      count_q       <= count_d;
      rate_data_q   <= rate_data_d;
      rate_strobe_q <= rate_strobe_d;
      burst_q       <= burst_d;
    end
  end

  assign overflow    = overflow_q;
  assign rate_data   = rate_data_q;
  assign rate_strobe = rate_strobe_q;
  assign burst_out   = burst_q;

endmodule

// File: tb/tb_alif_isi_monitor.sv
// Self-checking bench for alif_isi_monitor: timestamp/queue reference model plus directed literal checks.
module tb_alif_isi_monitor;

  localparam int D   = 4;
  localparam int WIN = 256;
  localparam int SAT = 255;

  logic       clk = 1'b0;
  logic       rst_n, ena, spike_in, isi_ready;
  logic [7:0] burst_thr;
  logic       isi_valid, overflow, rate_strobe, burst_out;
  logic [7:0] isi_data, rate_data;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  alif_isi_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .spike_in    (spike_in),
    .burst_thr   (burst_thr),
    .isi_valid   (isi_valid),
    .isi_ready   (isi_ready),
    .isi_data    (isi_data),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .rate_data   (rate_data),
    .rate_strobe (rate_strobe),
    .burst_out   (burst_out)
  );

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  // Reference model: ISIs from ena-cycle timestamps, FIFO as a queue, rate as spikes per WIN ena cycles.
  int unsigned mq[$];
  bit     armed = 0;
  longint et = 0, last_et = 0;
  bit     pend = 0;
  int     pend_isi = 0;
  bit     m_ovf = 0, m_strobe = 0, m_burst = 0;
  int     m_rate = 0, wcnt = 0, scnt = 0;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit popped;
    longint d;
    if (!rst_n) begin
      mq.delete();
      armed = 0; pend = 0; m_ovf = 0; m_rate = 0; m_strobe = 0; m_burst = 0;
      wcnt = 0; scnt = 0;
    end else begin
      popped  = isi_ready && (mq.size() > 0);
      m_burst = 0;
      if (popped) void'(mq.pop_front());
      if (pend) begin
`ifdef ALIF_ISI_BURST_EN
        m_burst = (pend_isi <= int'(burst_thr));
`endif
        if (mq.size() < D) mq.push_back(pend_isi);
        else m_ovf = 1;
      end
      pend = 0;
      m_strobe = 0;
      if (ena) begin
        et++;
        if (spike_in) begin
          if (armed) begin
            d = et - last_et;
            pend = 1;
            pend_isi = (d > SAT) ? SAT : int'(d);
          end
          armed = 1;
          last_et = et;
        end
        wcnt++;
        if (spike_in && scnt < SAT) scnt++;
        if (wcnt == WIN) begin
          m_rate = scnt; m_strobe = 1; wcnt = 0; scnt = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    cmp("isi_valid", isi_valid, mq.size() > 0);
    cmp("isi_data", isi_data, (mq.size() > 0) ? mq[0] : 0);
    cmp("fifo_level", fifo_level, mq.size());
    cmp("overflow", overflow, m_ovf);
    cmp("rate_data", rate_data, m_rate);
    cmp("rate_strobe", rate_strobe, m_strobe);
    cmp("burst_out", burst_out, m_burst);
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit rd);
    rst_n = r; ena = e; spike_in = s; isi_ready = rd;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1, 1, 0, rd);
  endtask

  int strobe_at[$];
  int bursts;
  int n_ena;
  bit e_r, s_r, rd_r, r_r;
  int phase;

  initial begin
    burst_thr = 8'd4;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    cmp("rst_valid", isi_valid, 0);
    cmp("rst_level", fifo_level, 0);
    cmp("rst_overflow", overflow, 0);
    cmp("rst_rate", rate_data, 0);

    // Spikes at relative cycles 0, 5, 25 -> ISIs 5 then 20.
    step(1, 1, 1, 1);
    step(1, 1, 0, 1);
    cmp("t1_no_first_entry", isi_valid, 0);
    idle(3, 1);
    step(1, 1, 1, 1);
    step(1, 1, 0, 1);
    cmp("t1_isi5", isi_data, 5);
    idle(18, 1);
    step(1, 1, 1, 1);
    step(1, 1, 0, 1);
    cmp("t1_isi20", isi_data, 20);

    // Six spikes three apart with ready low: four ISIs kept, the fifth dropped.
    step(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 1, 0);
      if (k < 5) idle(2, 0);
    end
    step(1, 1, 0, 0);
    cmp("t2_level_full", fifo_level, 4);
    cmp("t2_overflow", overflow, 1);
    for (int k = 0; k < 4; k++) begin
      cmp("t2_drain_isi", isi_data, 3);
      step(1, 1, 0, 1);
    end
    cmp("t2_empty", isi_valid, 0);

    // Full FIFO with a push landing on the same edge as a pop.
    step(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 1, 0);
      if (k < 4) idle(2, 0);
    end
    step(1, 1, 0, 0);
    cmp("t3_level_before", fifo_level, 4);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 1);
    cmp("t3_level_kept", fifo_level, 4);
    cmp("t3_no_overflow", overflow, 0);

    // Long gap saturates; spike held three cycles gives 1,1.
    step(0, 0, 0, 0);
    step(1, 1, 1, 0);
    idle(299, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    cmp("t4_level", fifo_level, 3);
    cmp("t4_isi_sat", isi_data, 255);
    step(1, 1, 0, 1);
    cmp("t4_isi_adjacent", isi_data, 1);

    // Rate windows: 16 spikes per window; 50 frozen cycles delay the second strobe.
    step(0, 0, 0, 0);
    n_ena = 0;
    for (int i = 0; i < 600; i++) begin
      e_r = !(i >= 300 && i < 350);
      s_r = e_r && (n_ena % 16 == 0);
      if (e_r) n_ena++;
      step(1, e_r, s_r, 1);
      if (rate_strobe) begin
        strobe_at.push_back(i);
        cmp("t5_rate16", rate_data, 16);
      end
    end
    cmp("t5_nstrobes", strobe_at.size(), 2);
    if (strobe_at.size() == 2) begin
      cmp("t5_strobe1_at", strobe_at[0], 255);
      cmp("t5_strobe2_at", strobe_at[1], 561);
    end

    // Burst compare on ISIs 3, 4, 5 with threshold 4; then reset mid-stream.
    step(0, 0, 0, 0);
    burst_thr = 8'd4;
    bursts = 0;
    step(1, 1, 1, 1);
    for (int g = 3; g <= 5; g++) begin
      for (int i = 0; i < g - 1; i++) begin
        step(1, 1, 0, 1);
        bursts += int'(burst_out);
      end
      step(1, 1, 1, 1);
      bursts += int'(burst_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 1);
      bursts += int'(burst_out);
    end
`ifdef ALIF_ISI_BURST_EN
    cmp("t6_burst_count", bursts, 2);
`else
    cmp("t6_burst_count", bursts, 0);
`endif
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    cmp("t6_rst_valid", isi_valid, 0);
    cmp("t6_rst_level", fifo_level, 0);
    cmp("t6_rst_data", isi_data, 0);
    cmp("t6_rst_burst", burst_out, 0);
    cmp("t6_rst_rate", rate_data, 0);

    // Randomized traffic with phases of dense, sparse and very sparse spiking.
    step(0, 0, 0, 0);
    for (int i = 0; i < 4500; i++) begin
      if (i % 500 == 0) burst_thr = 8'($urandom_range(0, 40));
      phase = (i / 500) % 3;
      r_r  = ($urandom_range(0, 1499) != 0);
      e_r  = ($urandom_range(0, 9) != 0);
      case (phase)
        0:       s_r = ($urandom_range(0, 1) == 0);
        1:       s_r = ($urandom_range(0, 9) == 0);
        default: s_r = ($urandom_range(0, 199) == 0);
      endcase
      rd_r = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      step(r_r, e_r, s_r, rd_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
